// File: rtl/struct_rec_fifo.sv
`default_nettype none
// ============================================================================
// Module      : struct_rec_fifo
// Description : First-word-fall-through FIFO of packed struct records
//               {tag, a, b, chk}. The check field is generated on push and
//               re-verified on pop; any mismatch raises a sticky flag.
// Revision    : 1.0 - initial release
// ============================================================================
module struct_rec_fifo #(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [TAG_W-1:0]            in_tag,
    input  logic [DATA_W-1:0]           in_a,
    input  logic [DATA_W-1:0]           in_b,
    input  logic                        inj_err,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [TAG_W-1:0]            out_tag,
    output logic [DATA_W-1:0]           out_a,
    output logic [DATA_W-1:0]           out_b,
    output logic [TAG_W+3*DATA_W-1:0]   out_rec,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        chk_err
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] chk;
    } rec_t;

    // Record storage; contents are don't-care until written, so no reset.
    rec_t r_mem [DEPTH];

    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_chk_err;

    rec_t              w_push_rec;
    rec_t              w_stored;
    rec_t              w_head;
    logic [DATA_W-1:0] w_in_tagx;
    logic [DATA_W-1:0] w_head_tagx;
    logic              w_push;
    logic              w_pop;
    logic              w_head_bad;

    // Tag folded into the check field: truncated when wider than the data
    // fields, zero-extended when narrower.
    if (TAG_W >= DATA_W) begin : g_tag_trunc
        assign w_in_tagx   = in_tag[DATA_W-1:0];
        assign w_head_tagx = w_stored.tag[DATA_W-1:0];
    end else begin : g_tag_zext
        assign w_in_tagx   = {{(DATA_W-TAG_W){1'b0}}, in_tag};
        assign w_head_tagx = {{(DATA_W-TAG_W){1'b0}}, w_stored.tag};
    end

    assign in_ready  = (r_count != c_cnt_full);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign count     = r_count;
    assign chk_err   = r_chk_err;

    // Assemble the incoming record; inj_err flips chk bit 0 as a fault hook.
    always_comb begin
        w_push_rec     = '0;
        w_push_rec.tag = in_tag;
        w_push_rec.a   = in_a;
        w_push_rec.b   = in_b;
        w_push_rec.chk = in_a ^ in_b ^ w_in_tagx ^ DATA_W'(inj_err);
    end

    // Head record, forced to zero while the FIFO is empty.
    always_comb begin
        w_stored   = r_mem[r_rd_ptr];
        w_head     = out_valid ? w_stored : '0;
        w_head_bad = (w_stored.a ^ w_stored.b ^ w_head_tagx) != w_stored.chk;
    end

    assign out_tag = w_head.tag;
    assign out_a   = w_head.a;
    assign out_b   = w_head.b;
    assign out_rec = w_head;

    // Whole-record write into the slot addressed by the write pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_rec;
        end
    end

    // Pointers, occupancy and sticky check-error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_chk_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
                if (w_head_bad) begin
                    r_chk_err <= 1'b1;
                end
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Structural invariants of the occupancy flags and output slicing.
    always_comb begin
        assert (r_count <= c_cnt_full);
        assert (out_valid == (r_count != '0));
        assert (in_ready == (r_count != c_cnt_full));
        if (out_valid) begin
            assert (out_rec[TAG_W+3*DATA_W-1:3*DATA_W] == out_tag);
            assert (out_rec[3*DATA_W-1:2*DATA_W] == out_a);
            assert (out_rec[2*DATA_W-1:DATA_W] == out_b);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_struct_rec_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_struct_rec_fifo
// Description : Scoreboard bench for struct_rec_fifo (default and wide
//               parameter sets) with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_struct_rec_fifo;

    localparam int DW = 8;
    localparam int TW = 4;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Default-parameter instance.
    logic          in_valid = 1'b0, in_ready, inj_err = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic [DW-1:0] in_a = '0, in_b = '0;
    logic          out_valid, out_ready = 1'b0, chk_err;
    logic [TW-1:0] out_tag;
    logic [DW-1:0] out_a, out_b;
    logic [TW+3*DW-1:0] out_rec;
    logic [2:0]    count;

    struct_rec_fifo #(.DATA_W(DW), .TAG_W(TW), .DEPTH(DP)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .inj_err(inj_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_a(out_a), .out_b(out_b), .out_rec(out_rec),
        .count(count), .chk_err(chk_err)
    );

    // Wide-tag, odd-depth instance.
    logic          v1 = 1'b0, rdy1, ordy1 = 1'b0, ov1, err1;
    logic [19:0]   tag1 = '0, otag1;
    logic [15:0]   a1 = '0, b1 = '0, oa1, ob1;
    logic [67:0]   orec1;
    logic [1:0]    cnt1;

    struct_rec_fifo #(.DATA_W(16), .TAG_W(20), .DEPTH(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1), .in_ready(rdy1),
        .in_tag(tag1), .in_a(a1), .in_b(b1), .inj_err(1'b0),
        .out_valid(ov1), .out_ready(ordy1),
        .out_tag(otag1), .out_a(oa1), .out_b(ob1), .out_rec(orec1),
        .count(cnt1), .chk_err(err1)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pushed records plus a sticky error flag.
    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        bit            bad;
    } exp_t;

    exp_t q[$];
    bit   exp_err = 1'b0;

    function automatic logic [TW+3*DW-1:0] rec_of(exp_t e);
        logic [DW-1:0] c;
        c = e.a ^ e.b ^ {{(DW-TW){1'b0}}, e.tag};
        c[0] = c[0] ^ e.bad;
        return {e.tag, e.a, e.b, c};
    endfunction

    task automatic model_step();
        int   sz;
        exp_t e;
        sz = q.size();
        if (out_ready && sz != 0) begin
            if (q[0].bad) exp_err = 1'b1;
            void'(q.pop_front());
        end
        if (in_valid && sz != DP) begin
            e.tag = in_tag; e.a = in_a; e.b = in_b; e.bad = inj_err;
            q.push_back(e);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            exp_err = 1'b0;
        end else begin
            model_step();
        end
    end

    // Monitor: compare DUT state and head record against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            check("count", count, q.size());
            check("in_ready", in_ready, q.size() != DP);
            check("out_valid", out_valid, q.size() != 0);
            check("chk_err", chk_err, exp_err);
            if (q.size() != 0) begin
                check("head_rec", out_rec, rec_of(q[0]));
                check("head_fields", {out_tag, out_a, out_b}, {q[0].tag, q[0].a, q[0].b});
            end else begin
                check("idle_zero", {out_rec, out_tag, out_a, out_b}, '0);
            end
        end
    end

    task automatic step(input logic v, input logic [TW-1:0] t, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic inj, input logic ordy);
        in_valid = v; in_tag = t; in_a = a; in_b = b; inj_err = inj; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic v, input logic [19:0] t, input logic [15:0] a,
                         input logic [15:0] b, input logic ordy);
        v1 = v; tag1 = t; a1 = a; b1 = b; ordy1 = ordy;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [67:0] rec1(logic [19:0] t, logic [15:0] a, logic [15:0] b);
        return {t, a, b, a ^ b ^ t[15:0]};
    endfunction

    logic [67:0] q1[$];

    initial begin
        // Reset
        #2 rst_n = 1'b0;
        #1;
        mon_en = 1'b1;
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_chk_err", chk_err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single push visible next cycle
        step(1, 4'h3, 8'hAA, 8'h55, 0, 0);
        check("first_rec", out_rec, 28'h3AA55FC);
        check("first_count", count, 1);

        // Fill to full, extra push ignored, drain in order
        for (int i = 0; i < 3; i++) step(1, 4'(i + 4), 8'(8'h10 + i), 8'(8'h20 + i), 0, 0);
        check("full_ready", in_ready, 0);
        check("full_count", count, 4);
        step(1, 4'hF, 8'hEE, 8'hDD, 0, 0);
        check("full_ignore", count, 4);
        for (int i = 0; i < 4; i++) step(0, '0, '0, '0, 0, 1);
        check("drained_valid", out_valid, 0);
        check("drained_rec", out_rec, 0);

        // Steady-state push+pop at count 2
        step(1, 4'h1, 8'h01, 8'h11, 0, 0);
        step(1, 4'h2, 8'h02, 8'h22, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 4'($urandom), 8'($urandom), 8'($urandom), 0, 1);
            check("steady_count", count, 2);
        end
        step(0, '0, '0, '0, 0, 1);
        step(0, '0, '0, '0, 0, 1);

        // Injected check error is sticky
        step(1, 4'h9, 8'h5A, 8'hC3, 1, 0);
        check("inj_not_yet", chk_err, 0);
        step(0, '0, '0, '0, 0, 1);
        check("inj_err_set", chk_err, 1);
        for (int i = 0; i < 6; i++) step(1, 4'($urandom), 8'($urandom), 8'($urandom), 0, 1'($urandom));
        check("inj_err_sticky", chk_err, 1);

        // Asynchronous reset with records held
        step(0, '0, '0, '0, 0, 1);
        step(0, '0, '0, '0, 0, 1);
        step(0, '0, '0, '0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 4'($urandom), 8'($urandom), 8'($urandom), 0, 0);
        check("pre_rst_count", count, 3);
        #3 rst_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_chk_err", chk_err, 0);
        check("arst_rec", out_rec, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic with occasional injected errors
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)));
        end
        step(0, '0, '0, '0, 0, 0);

        // Wide tag, DEPTH=3 instance
        step1(1, 20'hABCDE, 16'h1234, 16'h00FF, 0);
        check("w_first_rec", orec1, {20'hABCDE, 16'h1234, 16'h00FF, 16'hAE15});
        q1.push_back({20'hABCDE, 16'h1234, 16'h00FF, 16'hAE15});
        for (int i = 0; i < 2; i++) begin
            logic [19:0] t; logic [15:0] a, b;
            t = 20'($urandom); a = 16'($urandom); b = 16'($urandom);
            step1(1, t, a, b, 0);
            q1.push_back(rec1(t, a, b));
        end
        check("w_full_ready", rdy1, 0);
        check("w_full_count", cnt1, 3);
        step1(0, '0, '0, '0, 1);
        void'(q1.pop_front());
        check("w_head_after_pop", orec1, q1[0]);
        for (int i = 0; i < 6; i++) begin
            logic [19:0] t; logic [15:0] a, b;
            t = 20'($urandom); a = 16'($urandom); b = 16'($urandom);
            step1(1, t, a, b, 1);
            void'(q1.pop_front());
            q1.push_back(rec1(t, a, b));
            check("w_head", orec1, q1[0]);
            check("w_count", cnt1, 2);
        end
        check("w_chk_err", err1, 0);
        step1(0, '0, '0, '0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
